// File: rtl/exec_ctrl.sv
// -----------------------------------------------------------------------------
// exec_ctrl
//
// Execution controller for the ARM processor core. Produces the per-cycle
// clock-enable cpu_en that gates every architectural state update of the core.
// Supported modes (selected by `mode`, captured when `start` is accepted):
//   00 free-run          : execute until halt_req
//   01 single-step       : execute exactly one cycle (also launched by step_btn)
//   10 run-N             : execute exactly run_count cycles
//   11 run-to-breakpoint : execute until pc hits an enabled breakpoint
//
// Ports:
//   clk        system clock, everything on the rising edge
//   rst        asynchronous, active-low reset
//   mode       run mode, sampled on an accepted start
//   start      synchronous launch pulse, honoured only in IDLE
//   step_btn   asynchronous step button level (synchronised + edge detected)
//   halt_req   synchronous stop request, overrides everything
//   run_count  cycle budget for run-N, sampled on start
//   bp_addr    packed breakpoint addresses, entry i at [i*PC_W +: PC_W]
//   bp_en      per-breakpoint enable
//   pc         PC of the instruction executed when cpu_en is high
//   cpu_en     processor clock-enable (combinational from state and inputs)
//   running    registered, high whenever the controller is not IDLE
//   bp_hit     one-cycle registered pulse after a breakpoint stop
//   bp_idx     lowest matching breakpoint index, held until the next start
//   cycle_cnt  saturating count of cycles with cpu_en high since reset
// -----------------------------------------------------------------------------
module exec_ctrl #(
    parameter  int PC_W        = 32,
    parameter  int CNT_W       = 32,
    parameter  int NUM_BP      = 2,
    parameter  int SYNC_STAGES = 2,
    localparam int IDX_W       = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic                   start,
    input  logic                   step_btn,
    input  logic                   halt_req,
    input  logic [CNT_W-1:0]       run_count,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]      bp_en,
    input  logic [PC_W-1:0]        pc,
    output logic                   cpu_en,
    output logic                   running,
    output logic                   bp_hit,
    output logic [IDX_W-1:0]       bp_idx,
    output logic [CNT_W-1:0]       cycle_cnt
);

    localparam logic [1:0] MODE_FREE   = 2'b00;
    localparam logic [1:0] MODE_STEP   = 2'b01;
    localparam logic [1:0] MODE_RUN_N  = 2'b10;
    localparam logic [1:0] MODE_RUN_BP = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FREE   = 3'd1,
        ST_STEP   = 3'd2,
        ST_RUN_N  = 3'd3,
        ST_RUN_BP = 3'd4
    } state_t;

    state_t                 state_r;
    logic [CNT_W-1:0]       remaining_r;
    logic                   first_r;       // high during the first RUN_BP cycle
    logic                   running_r;
    logic                   bp_hit_r;
    logic [IDX_W-1:0]       bp_idx_r;
    logic [CNT_W-1:0]       cycle_cnt_r;
    logic [SYNC_STAGES-1:0] sync_r;        // sync_r[SYNC_STAGES-1] is the settled level
    logic                   edge_r;        // previous settled level for edge detection

    logic                   step_edge_s;
    logic                   match_s;
    logic [IDX_W-1:0]       match_idx_s;
    logic                   cpu_en_s;

    // Step button synchroniser chain followed by the edge-detect flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= '0;
            edge_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], step_btn};
            edge_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // A held button yields a single step: only the 0->1 transition counts.
    assign step_edge_s = sync_r[SYNC_STAGES-1] & ~edge_r;

    // Breakpoint comparators; scanning downwards leaves the lowest index.
    always_comb begin
        match_s     = 1'b0;
        match_idx_s = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en[i] && (pc == bp_addr[i*PC_W +: PC_W])) begin
                match_s     = 1'b1;
                match_idx_s = IDX_W'(i);
            end else begin
                match_s     = match_s;
                match_idx_s = match_idx_s;
            end
        end
    end

    // Clock-enable: low in IDLE, whenever halt_req is present, and in the
    // RUN_BP cycle that stops on a breakpoint (the first cycle never stops,
    // so a run can resume from the instruction it stopped on).
    always_comb begin
        cpu_en_s = 1'b0;
        case (state_r)
            ST_FREE, ST_STEP, ST_RUN_N: cpu_en_s = ~halt_req;
            ST_RUN_BP:                  cpu_en_s = ~halt_req & ~(match_s & ~first_r);
            default:                    cpu_en_s = 1'b0;
        endcase
    end

    // Main controller FSM with its registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            remaining_r <= '0;
            first_r     <= 1'b0;
            running_r   <= 1'b0;
            bp_hit_r    <= 1'b0;
            bp_idx_r    <= '0;
        end else begin
            bp_hit_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (halt_req) begin
                        // A stop request suppresses any launch in the same cycle.
                        state_r   <= ST_IDLE;
                        running_r <= 1'b0;
                    end else if (start) begin
                        bp_idx_r <= '0;
                        case (mode)
                            MODE_FREE: begin
                                state_r   <= ST_FREE;
                                running_r <= 1'b1;
                            end
                            MODE_STEP: begin
                                state_r   <= ST_STEP;
                                running_r <= 1'b1;
                            end
                            MODE_RUN_N: begin
                                if (run_count == '0) begin
                                    // Zero-length run: nothing to execute.
                                    state_r   <= ST_IDLE;
                                    running_r <= 1'b0;
                                end else begin
                                    remaining_r <= run_count;
                                    state_r     <= ST_RUN_N;
                                    running_r   <= 1'b1;
                                end
                            end
                            MODE_RUN_BP: begin
                                state_r   <= ST_RUN_BP;
                                first_r   <= 1'b1;
                                running_r <= 1'b1;
                            end
                            default: begin
                                state_r   <= ST_IDLE;
                                running_r <= 1'b0;
                            end
                        endcase
                    end else if (step_edge_s) begin
                        state_r   <= ST_STEP;
                        running_r <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        running_r <= 1'b0;
                    end
                end

                ST_FREE: begin
                    if (halt_req) begin
                        state_r   <= ST_IDLE;
                        running_r <= 1'b0;
                    end else begin
                        state_r   <= ST_FREE;
                        running_r <= 1'b1;
                    end
                end

                ST_STEP: begin
                    state_r   <= ST_IDLE;
                    running_r <= 1'b0;
                end

                ST_RUN_N: begin
                    if (halt_req || (remaining_r == CNT_W'(1))) begin
                        remaining_r <= '0;
                        state_r     <= ST_IDLE;
                        running_r   <= 1'b0;
                    end else begin
                        remaining_r <= remaining_r - CNT_W'(1);
                        state_r     <= ST_RUN_N;
                        running_r   <= 1'b1;
                    end
                end

                ST_RUN_BP: begin
                    first_r <= 1'b0;
                    if (halt_req) begin
                        state_r   <= ST_IDLE;
                        running_r <= 1'b0;
                    end else if (match_s && !first_r) begin
                        state_r   <= ST_IDLE;
                        running_r <= 1'b0;
                        bp_hit_r  <= 1'b1;
                        bp_idx_r  <= match_idx_s;
                    end else begin
                        state_r   <= ST_RUN_BP;
                        running_r <= 1'b1;
                    end
                end

                default: begin
                    state_r   <= ST_IDLE;
                    running_r <= 1'b0;
                    first_r   <= 1'b0;
                end
            endcase
        end
    end

    // Executed-cycle counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_r <= '0;
        end else if (cpu_en_s && (cycle_cnt_r != {CNT_W{1'b1}})) begin
            cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
        end else begin
            cycle_cnt_r <= cycle_cnt_r;
        end
    end

    assign cpu_en    = cpu_en_s;
    assign running   = running_r;
    assign bp_hit    = bp_hit_r;
    assign bp_idx    = bp_idx_r;
    assign cycle_cnt = cycle_cnt_r;

endmodule

// File: tb/tb_exec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exec_ctrl
//
// Self-checking bench for exec_ctrl. Inputs change 1 time unit after a rising
// edge; outputs are sampled on the following falling edge. For every driven
// cycle the expected outputs are pushed into a scoreboard queue and popped and
// compared at the sampling point. A second instance with CNT_W=4 exercises
// counter saturation.
// -----------------------------------------------------------------------------
module tb_exec_ctrl;

    localparam int PC_W        = 32;
    localparam int CNT_W       = 32;
    localparam int NUM_BP      = 2;
    localparam int SYNC_STAGES = 2;
    localparam int IDX_W       = 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [1:0]             mode;
    logic                   start;
    logic                   step_btn;
    logic                   halt_req;
    logic [CNT_W-1:0]       run_count;
    logic [NUM_BP*PC_W-1:0] bp_addr;
    logic [NUM_BP-1:0]      bp_en;
    logic [PC_W-1:0]        pc;
    logic                   cpu_en;
    logic                   running;
    logic                   bp_hit;
    logic [IDX_W-1:0]       bp_idx;
    logic [CNT_W-1:0]       cycle_cnt;
    logic                   sat_cpu_en;
    logic                   sat_running;
    logic                   sat_bp_hit;
    logic [IDX_W-1:0]       sat_bp_idx;
    logic [3:0]             sat_cycle_cnt;

    typedef struct packed {
        logic             en;
        logic             run;
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             e;
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [CNT_W-1:0] exp_cnt  = '0;
    logic [IDX_W-1:0] exp_idx  = '0;

    always #5 clk = ~clk;

    exec_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .NUM_BP(NUM_BP), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .step_btn(step_btn),
        .halt_req(halt_req), .run_count(run_count), .bp_addr(bp_addr), .bp_en(bp_en),
        .pc(pc), .cpu_en(cpu_en), .running(running), .bp_hit(bp_hit), .bp_idx(bp_idx),
        .cycle_cnt(cycle_cnt)
    );

    exec_ctrl #(.PC_W(PC_W), .CNT_W(4), .NUM_BP(NUM_BP), .SYNC_STAGES(SYNC_STAGES)) dut_sat (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .step_btn(step_btn),
        .halt_req(halt_req), .run_count(run_count[3:0]), .bp_addr(bp_addr), .bp_en(bp_en),
        .pc(pc), .cpu_en(sat_cpu_en), .running(sat_running), .bp_hit(sat_bp_hit),
        .bp_idx(sat_bp_idx), .cycle_cnt(sat_cycle_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record what the current cycle must look like; the count advances after.
    task automatic push_exp(input logic en, input logic run, input logic hit);
        exp_t t;
        t.en  = en;
        t.run = run;
        t.hit = hit;
        t.idx = exp_idx;
        t.cnt = exp_cnt;
        exp_q.push_back(t);
        if (en) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic test_reset();
        rst = 1'b0; mode = 2'b00; start = 1'b0; step_btn = 1'b0; halt_req = 1'b0;
        run_count = '0; bp_addr = '0; bp_en = '0; pc = '0;
        exp_cnt = '0; exp_idx = '0;
        repeat (2) tick();
        @(negedge clk);
        n_checks += 5;
        if (cpu_en !== 1'b0)    begin n_fail++; $display("FAIL reset cpu_en: got %b need 0", cpu_en); end
        if (running !== 1'b0)   begin n_fail++; $display("FAIL reset running: got %b need 0", running); end
        if (bp_hit !== 1'b0)    begin n_fail++; $display("FAIL reset bp_hit: got %b need 0", bp_hit); end
        if (bp_idx !== 1'b0)    begin n_fail++; $display("FAIL reset bp_idx: got %0d need 0", bp_idx); end
        if (cycle_cnt !== '0)   begin n_fail++; $display("FAIL reset cycle_cnt: got %0d need 0", cycle_cnt); end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = (i == 0);
            push_exp(i > 0, i > 0, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks += 5;
            if (cpu_en !== e.en)     begin n_fail++; $display("FAIL reset_free cpu_en cyc %0d: got %b need %b", i, cpu_en, e.en); end
            if (running !== e.run)   begin n_fail++; $display("FAIL reset_free running cyc %0d: got %b need %b", i, running, e.run); end
            if (bp_hit !== e.hit)    begin n_fail++; $display("FAIL reset_free bp_hit cyc %0d: got %b need %b", i, bp_hit, e.hit); end
            if (bp_idx !== e.idx)    begin n_fail++; $display("FAIL reset_free bp_idx cyc %0d: got %0d need %0d", i, bp_idx, e.idx); end
            if (cycle_cnt !== e.cnt) begin n_fail++; $display("FAIL reset_free cycle_cnt cyc %0d: got %0d need %0d", i, cycle_cnt, e.cnt); end
        end
        // Asynchronous reset while clk is low and FREE is executing.
        #2;
        rst = 1'b0;
        #1;
        n_checks += 3;
        if (cpu_en !== 1'b0)  begin n_fail++; $display("FAIL async_rst cpu_en: got %b need 0", cpu_en); end
        if (running !== 1'b0) begin n_fail++; $display("FAIL async_rst running: got %b need 0", running); end
        if (cycle_cnt !== '0) begin n_fail++; $display("FAIL async_rst cycle_cnt: got %0d need 0", cycle_cnt); end
        exp_cnt = '0; exp_idx = '0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            push_exp(1'b0, 1'b0, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks += 3;
            if (cpu_en !== e.en)     begin n_fail++; $display("FAIL idle_after_rst cpu_en cyc %0d: got %b need %b", i, cpu_en, e.en); end
            if (running !== e.run)   begin n_fail++; $display("FAIL idle_after_rst running cyc %0d: got %b need %b", i, running, e.run); end
            if (cycle_cnt !== e.cnt) begin n_fail++; $display("FAIL idle_after_rst cycle_cnt cyc %0d: got %0d need %0d", i, cycle_cnt, e.cnt); end
        end
    endtask

    task automatic test_run_n();
        for (int i = 0; i < 9; i++) begin
            tick();
            mode = 2'b10;
            start = (i == 0);
            run_count = (i == 0) ? 32'd5 : 32'd9;  // later change must be ignored
            push_exp(i >= 1 && i <= 5, i >= 1 && i <= 5, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks += 5;
            if (cpu_en !== e.en)     begin n_fail++; $display("FAIL run_n cpu_en cyc %0d: got %b need %b", i, cpu_en, e.en); end
            if (running !== e.run)   begin n_fail++; $display("FAIL run_n running cyc %0d: got %b need %b", i, running, e.run); end
            if (bp_hit !== e.hit)    begin n_fail++; $display("FAIL run_n bp_hit cyc %0d: got %b need %b", i, bp_hit, e.hit); end
            if (bp_idx !== e.idx)    begin n_fail++; $display("FAIL run_n bp_idx cyc %0d: got %0d need %0d", i, bp_idx, e.idx); end
            if (cycle_cnt !== e.cnt) begin n_fail++; $display("FAIL run_n cycle_cnt cyc %0d: got %0d need %0d", i, cycle_cnt, e.cnt); end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            run_count = '0;
            start = (i == 0);
            push_exp(1'b0, 1'b0, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks += 3;
            if (cpu_en !== e.en)     begin n_fail++; $display("FAIL run_zero cpu_en cyc %0d: got %b need %b", i, cpu_en, e.en); end
            if (running !== e.run)   begin n_fail++; $display("FAIL run_zero running cyc %0d: got %b need %b", i, running, e.run); end
            if (cycle_cnt !== e.cnt) begin n_fail++; $display("FAIL run_zero cycle_cnt cyc %0d: got %0d need %0d", i, cycle_cnt, e.cnt); end
        end
    endtask

    task automatic test_step();
        // Held button: single pulse SYNC_STAGES+1 edges after it is first sampled.
        for (int i = 0; i < 14; i++) begin
            tick();
            mode = 2'b00;
            start = 1'b0;
            step_btn = (i <= 9);
            push_exp(i == 3, i == 3, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks += 3;
            if (cpu_en !== e.en)     begin n_fail++; $display("FAIL step_held cpu_en cyc %0d: got %b need %b", i, cpu_en, e.en); end
            if (running !== e.run)   begin n_fail++; $display("FAIL step_held running cyc %0d: got %b need %b", i, running, e.run); end
            if (cycle_cnt !== e.cnt) begin n_fail++; $display("FAIL step_held cycle_cnt cyc %0d: got %0d need %0d", i, cycle_cnt, e.cnt); end
        end
        // Step press and a second start during RUN_N are both dropped.
        for (int i = 0; i < 11; i++) begin
            tick();
            mode = 2'b10;
            run_count = 32'd6;
            start = (i == 0 || i == 3);
            step_btn = (i >= 1 && i <= 3);
            push_exp(i >= 1 && i <= 6, i >= 1 && i <= 6, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks += 3;
            if (cpu_en !== e.en)     begin n_fail++; $display("FAIL step_in_run cpu_en cyc %0d: got %b need %b", i, cpu_en, e.en); end
            if (running !== e.run)   begin n_fail++; $display("FAIL step_in_run running cyc %0d: got %b need %b", i, running, e.run); end
            if (cycle_cnt !== e.cnt) begin n_fail++; $display("FAIL step_in_run cycle_cnt cyc %0d: got %0d need %0d", i, cycle_cnt, e.cnt); end
        end
    endtask

    task automatic test_breakpoint();
        bp_addr = {32'h0000_0020, 32'h0000_0010};  // entry 0 disabled
        bp_en   = 2'b10;
        mode    = 2'b11;
        // Run from 0x0, stop at 0x20.
        for (int i = 0; i < 12; i++) begin
            tick();
            start = (i == 0);
            pc = (i == 0) ? 32'h0 : ((i <= 9) ? PC_W'(4 * (i - 1)) : 32'h20);
            push_exp(i >= 1 && i <= 8, i >= 1 && i <= 9, i == 10);
            if (i == 9) exp_idx = 1'b1;
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks += 5;
            if (cpu_en !== e.en)     begin n_fail++; $display("FAIL bp_run cpu_en cyc %0d: got %b need %b", i, cpu_en, e.en); end
            if (running !== e.run)   begin n_fail++; $display("FAIL bp_run running cyc %0d: got %b need %b", i, running, e.run); end
            if (bp_hit !== e.hit)    begin n_fail++; $display("FAIL bp_run bp_hit cyc %0d: got %b need %b", i, bp_hit, e.hit); end
            if (bp_idx !== e.idx)    begin n_fail++; $display("FAIL bp_run bp_idx cyc %0d: got %0d need %0d", i, bp_idx, e.idx); end
            if (cycle_cnt !== e.cnt) begin n_fail++; $display("FAIL bp_run cycle_cnt cyc %0d: got %0d need %0d", i, cycle_cnt, e.cnt); end
        end
        // Resume from 0x20: the first cycle executes despite the match.
        for (int i = 0; i < 6; i++) begin
            tick();
            start = (i == 0);
            halt_req = (i == 4);
            pc = (i <= 1) ? 32'h20 : PC_W'(32'h20 + 4 * (i - 1));
            push_exp(i >= 1 && i <= 3, i >= 1 && i <= 4, 1'b0);
            if (i == 0) exp_idx = 1'b0;
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks += 5;
            if (cpu_en !== e.en)     begin n_fail++; $display("FAIL bp_resume cpu_en cyc %0d: got %b need %b", i, cpu_en, e.en); end
            if (running !== e.run)   begin n_fail++; $display("FAIL bp_resume running cyc %0d: got %b need %b", i, running, e.run); end
            if (bp_hit !== e.hit)    begin n_fail++; $display("FAIL bp_resume bp_hit cyc %0d: got %b need %b", i, bp_hit, e.hit); end
            if (bp_idx !== e.idx)    begin n_fail++; $display("FAIL bp_resume bp_idx cyc %0d: got %0d need %0d", i, bp_idx, e.idx); end
            if (cycle_cnt !== e.cnt) begin n_fail++; $display("FAIL bp_resume cycle_cnt cyc %0d: got %0d need %0d", i, cycle_cnt, e.cnt); end
        end
        // Both comparators hit the same address: the lower index is reported.
        bp_addr = {32'h0000_0030, 32'h0000_0030};
        bp_en   = 2'b11;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = (i == 0);
            halt_req = 1'b0;
            pc = (i <= 1) ? 32'h2C : 32'h30;
            push_exp(i == 1, i == 1 || i == 2, i == 3);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks += 5;
            if (cpu_en !== e.en)     begin n_fail++; $display("FAIL bp_lowest cpu_en cyc %0d: got %b need %b", i, cpu_en, e.en); end
            if (running !== e.run)   begin n_fail++; $display("FAIL bp_lowest running cyc %0d: got %b need %b", i, running, e.run); end
            if (bp_hit !== e.hit)    begin n_fail++; $display("FAIL bp_lowest bp_hit cyc %0d: got %b need %b", i, bp_hit, e.hit); end
            if (bp_idx !== e.idx)    begin n_fail++; $display("FAIL bp_lowest bp_idx cyc %0d: got %0d need %0d", i, bp_idx, e.idx); end
            if (cycle_cnt !== e.cnt) begin n_fail++; $display("FAIL bp_lowest cycle_cnt cyc %0d: got %0d need %0d", i, cycle_cnt, e.cnt); end
        end
        bp_en = 2'b00;
    endtask

    task automatic test_halt();
        for (int i = 0; i < 11; i++) begin
            tick();
            mode = 2'b00;
            start = (i == 0);
            halt_req = (i == 8);
            push_exp(i >= 1 && i <= 7, i >= 1 && i <= 8, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks += 3;
            if (cpu_en !== e.en)     begin n_fail++; $display("FAIL halt_free cpu_en cyc %0d: got %b need %b", i, cpu_en, e.en); end
            if (running !== e.run)   begin n_fail++; $display("FAIL halt_free running cyc %0d: got %b need %b", i, running, e.run); end
            if (cycle_cnt !== e.cnt) begin n_fail++; $display("FAIL halt_free cycle_cnt cyc %0d: got %0d need %0d", i, cycle_cnt, e.cnt); end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            start = (i == 0);
            halt_req = (i == 0);
            push_exp(1'b0, 1'b0, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks += 3;
            if (cpu_en !== e.en)     begin n_fail++; $display("FAIL halt_start cpu_en cyc %0d: got %b need %b", i, cpu_en, e.en); end
            if (running !== e.run)   begin n_fail++; $display("FAIL halt_start running cyc %0d: got %b need %b", i, running, e.run); end
            if (cycle_cnt !== e.cnt) begin n_fail++; $display("FAIL halt_start cycle_cnt cyc %0d: got %0d need %0d", i, cycle_cnt, e.cnt); end
        end
    endtask

    task automatic test_saturation();
        tick();
        rst = 1'b0;
        start = 1'b0;
        halt_req = 1'b0;
        exp_cnt = '0;
        exp_idx = '0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 22; i++) begin
            tick();
            mode = 2'b00;
            start = (i == 0);
            halt_req = (i == 21);
            push_exp(i >= 1 && i <= 20, i >= 1 && i <= 21, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks += 3;
            if (cpu_en !== e.en)     begin n_fail++; $display("FAIL sat_free cpu_en cyc %0d: got %b need %b", i, cpu_en, e.en); end
            if (running !== e.run)   begin n_fail++; $display("FAIL sat_free running cyc %0d: got %b need %b", i, running, e.run); end
            if (cycle_cnt !== e.cnt) begin n_fail++; $display("FAIL sat_free cycle_cnt cyc %0d: got %0d need %0d", i, cycle_cnt, e.cnt); end
            if (i == 10) begin
                n_checks++;
                if (sat_cycle_cnt !== 4'd9) begin n_fail++; $display("FAIL sat_mid cycle_cnt: got %0d need 9", sat_cycle_cnt); end
            end
            if (i == 21) begin
                n_checks++;
                if (sat_cycle_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_end cycle_cnt: got %0d need 15", sat_cycle_cnt); end
            end
        end
        tick();
        halt_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_run_n();
        test_step();
        test_breakpoint();
        test_halt();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
